// File: rtl/clk_div_pkg.sv
`default_nettype none
// ============================================================================
// Module   : clk_div_pkg
// Brief    : Shared constants, load classification and high-window helper
//            for the programmable clock divider.
// Revision : 1.0  initial release
// ============================================================================
package clk_div_pkg;

  localparam int          CNT_W_DEFAULT = 8;
  localparam int unsigned MIN_DIV       = 2;

  typedef enum logic [1:0] {
    LD_NONE   = 2'd0,
    LD_ACCEPT = 2'd1,
    LD_REJECT = 2'd2
  } load_kind_e;

  // Number of high cycles in a period of n clocks: ceil(n/2).
  function automatic logic [31:0] high_cnt(input logic [31:0] n);
    return (n + 32'd1) >> 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/clk_div_negstage.sv
`default_nettype none
// ============================================================================
// Module   : clk_div_negstage
// Brief    : Falling-edge retime flop with synchronous clear; the only
//            negedge logic in the divider.
// Revision : 1.0  initial release
// ============================================================================
module clk_div_negstage (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  always_ff @(negedge clk) begin
    if (rst) begin
      q <= 1'b0;
    end else begin
      q <= d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/clk_div_prog.sv
`default_nettype none
// ============================================================================
// Module   : clk_div_prog
// Brief    : Programmable integer clock divider with run-time reload and an
//            optional true-50% duty mode for odd ratios.
// Revision : 1.0  initial release
// ============================================================================
module clk_div_prog
  import clk_div_pkg::*;
#(
  parameter int CNT_W    = CNT_W_DEFAULT,
  parameter int DEF_DIV  = 5,
  parameter bit DEF_HALF = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [CNT_W-1:0] div_in,
  input  logic             half_in,
  input  logic             div_load,
  output logic             outclk,
  output logic             tick,
  output logic [CNT_W-1:0] div_cur,
  output logic             load_ack,
  output logic             load_err
);

  localparam logic [CNT_W-1:0] C_DEF_N   = CNT_W'(DEF_DIV);
  localparam logic [CNT_W-1:0] C_DEF_CNT = CNT_W'(DEF_DIV - 1);
  localparam logic [CNT_W-1:0] C_ONE     = CNT_W'(1);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_n;
  logic [CNT_W-1:0] r_n_p;
  logic             r_half;
  logic             r_half_p;
  logic             r_pend;
  logic             r_pos;
  logic             r_tick;
  logic             r_ack;
  logic             r_err;
  logic             w_neg;

  logic             w_wrap;
  logic             w_apply;
  logic [CNT_W-1:0] w_cnt_next;
  logic [CNT_W-1:0] w_n_eff;
  load_kind_e       w_ld;

  always_comb begin
    w_wrap     = (r_cnt == (r_n - C_ONE));
    w_cnt_next = w_wrap ? '0 : (r_cnt + C_ONE);
    w_apply    = w_wrap && r_pend;
    // The high window of a new period is sized from the divisor that takes effect on this edge.
    w_n_eff    = w_apply ? r_n_p : r_n;
    w_ld       = LD_NONE;
    if (div_load) begin
      w_ld = (32'(div_in) >= MIN_DIV) ? LD_ACCEPT : LD_REJECT;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt    <= C_DEF_CNT;
      r_n      <= C_DEF_N;
      r_half   <= DEF_HALF;
      r_n_p    <= C_DEF_N;
      r_half_p <= DEF_HALF;
      r_pend   <= 1'b0;
      r_pos    <= 1'b0;
      r_tick   <= 1'b0;
      r_ack    <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_tick <= 1'b0;
      r_ack  <= 1'b0;
      r_err  <= (w_ld == LD_REJECT);
      if (en) begin
        r_cnt  <= w_cnt_next;
        r_pos  <= (32'(w_cnt_next) < high_cnt(32'(w_n_eff)));
        r_tick <= (w_cnt_next == '0);
        if (w_apply) begin
          r_n    <= r_n_p;
          r_half <= r_half_p;
          r_pend <= 1'b0;
          r_ack  <= 1'b1;
        end
      end
      // A capture on a wrap edge overrides the pend clear, so it waits for the next wrap.
      if (w_ld == LD_ACCEPT) begin
        r_n_p    <= div_in;
        r_half_p <= half_in;
        r_pend   <= 1'b1;
      end
    end
  end

  clk_div_negstage u_negstage (
    .clk (clk),
    .rst (rst),
    .d   (r_pos),
    .q   (w_neg)
  );

  always_comb begin
    outclk = (r_n[0] && r_half) ? (r_pos & w_neg) : r_pos;
  end

  assign tick     = r_tick;
  assign div_cur  = r_n;
  assign load_ack = r_ack;
  assign load_err = r_err;

endmodule
`default_nettype wire
